regbank_wb_arbiter: RTL and testbench
=====================================

Name: regbank_wb_arbiter

Overview:
- Shares the register bank's single write port (RegWrite/WriteAddr/WriteData) between NUM_REQ writeback requesters, e.g. ALU result and load result.
- Round-robin arbitration with valid/ready handshakes.
- Registers the granted write for one cycle before it reaches the bank.
- Forwards that in-flight write to the two read ports so readers never see stale data.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..8).
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data; same packing.
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when valid && ready.
- wb_stall  in  1  when 1, no grants this cycle.
- RegWrite  out  1  write enable to register bank.
- WriteAddr  out  ADDR_W  bank write address.
- WriteData  out  DATA_W  bank write data.
- ReadAddr1, ReadAddr2  in  ADDR_W  bank read addresses, snooped for forwarding.
- fwd_hit1, fwd_hit2  out  1  in-flight write targets the corresponding read address.
- fwd_data1, fwd_data2  out  DATA_W  forwarded data; equals WriteData.
- contention_cnt  out  CNT_W  saturating count of cycles with more than one valid request.

Behaviour:
- Reset (async, rst_n=0) clears:
  - RegWrite=0, WriteAddr=0, WriteData=0.
  - rr_ptr=0, contention_cnt=0.
  - req_ready=0 while rst_n=0.
  - An accepted write still in the output register is discarded and never reaches the bank.
- Grant rules:
  - Combinational.
  - Grant goes to the first i with req_valid[i]=1, searching cyclically from rr_ptr.
  - req_ready is one-hot or zero, and is zero whenever wb_stall=1.
  - req_ready never asserts without req_valid.
- Pointer update: on a transfer by requester g, rr_ptr <= (g+1) mod NUM_REQ at the edge. rr_ptr is unchanged when there is no transfer.
- Output stage:
  - At the edge after a transfer with addr!=0: RegWrite<=1, WriteAddr<=addr, WriteData<=data.
  - With no transfer: RegWrite<=0, and WriteAddr/WriteData hold their previous values.
  - Register 0 writes are accepted (ready given, pointer advances) but dropped: RegWrite<=0.
- Latency: a transfer at edge N gives RegWrite=1 during cycle N+1, and the bank captures the write at edge N+1. Throughput is one write per cycle.
- Requesters hold valid/addr/data stable until granted. Deasserting valid before the grant is legal; nothing is written.
- Same destination address from two requesters in one cycle: serialized in round-robin order, no merging. The later grant wins in the bank.
- Forwarding:
  - fwd_hitK = RegWrite && (WriteAddr==ReadAddrK) && (ReadAddrK!=0).
  - fwd_dataK = WriteData.
  - Purely combinational from registered state.
- contention_cnt increments when popcount(req_valid)>1 and rst_n=1, regardless of wb_stall. It saturates at all-ones.
- wb_stall while a write is in flight does not cancel it: that write still completes. Only new grants are blocked.

Decomposition:
- Package wb_pkg: DATA_W, ADDR_W, REG_ZERO=0, and a wb_req_t struct {valid, addr, data}.
- One sub-module, rr_arbiter (parameter N):
  - Inputs: req[N], ptr, enable.
  - Output: one-hot gnt[N] and the encoded index.
  - Purely combinational.
- The top level holds rr_ptr, the output register, forwarding compare and counter.

Test Plan:
- Single requester, no stall: req0 addr=5 data=0xDEADBEEF, valid one cycle -> ready0=1 that cycle; next cycle RegWrite=1, WriteAddr=5, WriteData=0xDEADBEEF; cycle after, RegWrite=0.
- Both valid continuously, rr_ptr=0 after reset:
  - req0 addr=3 data=0x11, req1 addr=4 data=0x22.
  - Grants go 0,1,0,1 -> WriteAddr sequence 3,4,3,4 on consecutive cycles.
  - contention_cnt increments every cycle.
- Register 0 drop: req1 addr=0 data=0xFFFF, valid -> ready1=1, RegWrite stays 0, rr_ptr becomes 0.
- Forwarding:
  - Transfer addr=7 data=0xCAFE; during the RegWrite cycle drive ReadAddr1=7, ReadAddr2=8 -> fwd_hit1=1, fwd_data1=0xCAFE, fwd_hit2=0.
  - With ReadAddr1=0 -> fwd_hit1=0.
- Stall and reset:
  - wb_stall=1 with both valid -> ready=00, RegWrite=0 next cycle, rr_ptr unchanged.
  - Release stall, transfer, then pulse rst_n=0 mid-cycle before the next edge -> RegWrite, WriteAddr and contention_cnt drop to 0 immediately; no bank write occurs.
- Counter saturation: CNT_W=4, 20 cycles with both valid -> contention_cnt holds 15.

Source files
------------

// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared widths and the writeback request record for the register-bank write-port arbiter.
package wb_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regbank_wb_arbiter_if.sv
// Writeback requester bundle: packed per-requester valid/addr/data plus the one-hot ready.
interface regbank_wb_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = wb_pkg::ADDR_W,
  parameter int DATA_W  = wb_pkg::DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_addr, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_addr, input  req_data, output req_ready);
endinterface

// File: rtl/regbank_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to index 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  logic [N-1:0] req_hi;

  // Requests at or above the pointer win before the wrapped-around ones.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign req_hi[gi] = req[gi] && (gi >= int'(ptr));
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    if (enable) begin
      if (|req_hi) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (req_hi[i]) idx = PW'(i);
        end
      end else begin
        for (int i = N - 1; i >= 0; i--) begin
          if (req[i]) idx = PW'(i);
        end
      end
      if (|req) gnt[idx] = 1'b1;
    end
  end
endmodule

// File: rtl/regbank_wb_arbiter.sv
// Shares the register bank write port among writeback requesters; the granted write is
// registered for one cycle and forwarded to both read ports while in flight.
module regbank_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = wb_pkg::DATA_W,
  parameter int ADDR_W  = wb_pkg::ADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regbank_wb_arbiter_if.slave   req_if,
  input  logic                  wb_stall,
  output logic                  RegWrite,
  output logic [ADDR_W-1:0]     WriteAddr,
  output logic [DATA_W-1:0]     WriteData,
  input  logic [ADDR_W-1:0]     ReadAddr1,
  input  logic [ADDR_W-1:0]     ReadAddr2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_W-1:0]     fwd_data1,
  output logic [DATA_W-1:0]     fwd_data2,
  output logic [CNT_W-1:0]      contention_cnt
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]  write_addr_q, write_addr_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               transfer;
  logic               multi_req;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_data;

  // Gating with rst_n keeps ready low for the whole time reset is asserted.
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr_arbiter (
    .req    (req_if.req_valid),
    .ptr    (rr_ptr_q),
    .enable (!wb_stall && rst_n),
    .gnt    (gnt),
    .idx    (gnt_idx)
  );

  assign req_if.req_ready = gnt;
  assign transfer         = |gnt;
  assign multi_req        = $countones(req_if.req_valid) > 1;
  assign g_addr           = req_if.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign g_data           = req_if.req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    cnt_d        = cnt_q;
    if (transfer) begin
      rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      // Register 0 is hardwired: the request is consumed but never written.
      if (g_addr != ADDR_W'(wb_pkg::REG_ZERO)) begin
        reg_write_d  = 1'b1;
        write_addr_d = g_addr;
        write_data_d = g_data;
      end
    end
    if (multi_req && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign RegWrite       = reg_write_q;
  assign WriteAddr      = write_addr_q;
  assign WriteData      = write_data_q;
  assign contention_cnt = cnt_q;

  assign fwd_hit1  = reg_write_q && (write_addr_q == ReadAddr1) && (ReadAddr1 != '0);
  assign fwd_hit2  = reg_write_q && (write_addr_q == ReadAddr2) && (ReadAddr2 != '0);
  assign fwd_data1 = write_data_q;
  assign fwd_data2 = write_data_q;
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed plus random bench for regbank_wb_arbiter with a transaction-level reference model.
module tb_regbank_wb_arbiter;
  import wb_pkg::*;

  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbank_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) req_if ();

  logic          wb_stall;
  logic          RegWrite;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadAddr1, ReadAddr2;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic [CW-1:0] contention_cnt;

  regbank_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_if         (req_if),
    .wb_stall       (wb_stall),
    .RegWrite       (RegWrite),
    .WriteAddr      (WriteAddr),
    .WriteData      (WriteData),
    .ReadAddr1      (ReadAddr1),
    .ReadAddr2      (ReadAddr2),
    .fwd_hit1       (fwd_hit1),
    .fwd_hit2       (fwd_hit2),
    .fwd_data1      (fwd_data1),
    .fwd_data2      (fwd_data2),
    .contention_cnt (contention_cnt)
  );

  // Reference model: pointer, the write currently in flight, contention count,
  // and the architectural register contents once in-flight writes commit.
  int            m_ptr, m_cnt;
  bit            m_wr;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] committed [32];
  logic [DW-1:0] bank [32];
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wb_req_t mk(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {v, a, d};
  endfunction

  task automatic do_reset();
    req_if.req_valid = '1;
    wb_stall = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_waddr", 32'(WriteAddr), 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_cnt", 32'(contention_cnt), 32'd0);
    chk("rst_ready", 32'(req_if.req_ready), 32'd0);
    req_if.req_valid = '0;
    #1;
    rst_n = 1'b1;
    m_ptr = 0; m_cnt = 0; m_wr = 1'b0; m_waddr = '0; m_wdata = '0;
    @(negedge clk);
  endtask

  // One clock cycle: drive, check combinational and registered outputs, cross the edge.
  task automatic step(input wb_req_t r0, input wb_req_t r1, input logic st,
                      input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    int            g;
    logic [NR-1:0] v;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic          bw_en;
    logic [AW-1:0] bw_a;
    logic [DW-1:0] bw_d;
    logic [DW-1:0] seen;
    logic          hit1, hit2;
    v = {r1.valid, r0.valid};
    req_if.req_valid = v;
    req_if.req_addr  = {r1.addr, r0.addr};
    req_if.req_data  = {r1.data, r0.data};
    wb_stall = st; ReadAddr1 = ra1; ReadAddr2 = ra2;
    #1;
    g = -1;
    if (!st) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
    end
    hit1 = m_wr && (m_waddr == ra1) && (ra1 != 0);
    hit2 = m_wr && (m_waddr == ra2) && (ra2 != 0);
    chk("ready", 32'(req_if.req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
    chk("regwrite", 32'(RegWrite), 32'(m_wr));
    chk("waddr", 32'(WriteAddr), 32'(m_waddr));
    chk("wdata", WriteData, m_wdata);
    chk("cnt", 32'(contention_cnt), 32'(m_cnt));
    chk("hit1", 32'(fwd_hit1), 32'(hit1));
    chk("hit2", 32'(fwd_hit2), 32'(hit2));
    chk("fdata1", fwd_data1, m_wdata);
    chk("fdata2", fwd_data2, m_wdata);
    seen = fwd_hit1 ? fwd_data1 : bank[ra1];
    chk("view1", seen, hit1 ? m_wdata : committed[ra1]);
    seen = fwd_hit2 ? fwd_data2 : bank[ra2];
    chk("view2", seen, hit2 ? m_wdata : committed[ra2]);
    $display("cyc t=%0t valid=%b stall=%b grant=%0d regwrite=%b waddr=%0d cnt=%0d",
             $time, v, st, g, RegWrite, WriteAddr, contention_cnt);
    bw_en = RegWrite; bw_a = WriteAddr; bw_d = WriteData;
    @(posedge clk);
    if (bw_en) bank[bw_a] = bw_d;
    if (m_wr) committed[m_waddr] = m_wdata;
    m_wr = 1'b0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NR;
      ga = (g == 1) ? r1.addr : r0.addr;
      gd = (g == 1) ? r1.data : r0.data;
      if (ga != 0) begin
        m_wr = 1'b1; m_waddr = ga; m_wdata = gd;
      end
    end
    if ($countones(v) > 1 && m_cnt < CNT_MAX) m_cnt++;
    @(negedge clk);
  endtask

  initial begin
    wb_req_t idle;
    idle = mk(1'b0, '0, '0);
    for (int i = 0; i < 32; i++) begin
      committed[i] = '0;
      bank[i] = '0;
    end
    req_if.req_valid = '0; req_if.req_addr = '0; req_if.req_data = '0;
    wb_stall = 1'b0; ReadAddr1 = '0; ReadAddr2 = '0;
    do_reset();

    // Single requester
    step(mk(1'b1, 5'd5, 32'hDEADBEEF), idle, 1'b0, 5'd0, 5'd0);
    chk("single_addr", 32'(WriteAddr), 32'd5);
    chk("single_data", WriteData, 32'hDEADBEEF);
    step(idle, idle, 1'b0, 5'd5, 5'd0);
    chk("single_done", 32'(RegWrite), 32'd0);

    // Alternating grants from a fresh pointer
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(mk(1'b1, 5'd3, 32'h11), mk(1'b1, 5'd4, 32'h22), 1'b0, 5'd3, 5'd4);
      chk("rr_seq", 32'(WriteAddr), (k % 2 == 0) ? 32'd3 : 32'd4);
    end

    // Register 0 request consumed, no write
    step(idle, mk(1'b1, 5'd0, 32'hFFFF), 1'b0, 5'd4, 5'd0);
    chk("r0_drop", 32'(RegWrite), 32'd0);
    step(mk(1'b1, 5'd10, 32'hA), mk(1'b1, 5'd11, 32'hB), 1'b0, 5'd0, 5'd0);
    chk("r0_ptr", 32'(WriteAddr), 32'd10);

    // Forwarding
    step(mk(1'b1, 5'd7, 32'hCAFE), idle, 1'b0, 5'd0, 5'd0);
    ReadAddr1 = 5'd7; ReadAddr2 = 5'd8;
    #1;
    chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
    chk("fwd_data1", fwd_data1, 32'hCAFE);
    chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
    ReadAddr1 = 5'd0;
    #1;
    chk("fwd_zero", 32'(fwd_hit1), 32'd0);
    step(idle, idle, 1'b0, 5'd7, 5'd8);

    // Stall holds off grants and the pointer
    step(mk(1'b1, 5'd12, 32'hC), mk(1'b1, 5'd13, 32'hD), 1'b1, 5'd12, 5'd13);
    chk("stall_nowrite", 32'(RegWrite), 32'd0);
    step(mk(1'b1, 5'd12, 32'hC), mk(1'b1, 5'd13, 32'hD), 1'b0, 5'd12, 5'd13);

    // Reset discards the in-flight write
    step(mk(1'b1, 5'd9, 32'h1234), idle, 1'b0, 5'd0, 5'd0);
    chk("pre_rst_write", 32'(RegWrite), 32'd1);
    do_reset();
    step(idle, idle, 1'b0, 5'd9, 5'd0);
    chk("rst_discard", bank[9], 32'd0);

    // Counter saturation
    for (int k = 0; k < 20; k++) begin
      step(mk(1'b1, 5'(1 + k % 7), 32'(k)), mk(1'b1, 5'(2 + k % 5), 32'(k + 100)),
           1'b0, 5'(k % 8), 5'((k + 3) % 8));
    end
    chk("cnt_sat", 32'(contention_cnt), 32'(CNT_MAX));

    // Random traffic
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom),
           mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom),
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    step(idle, idle, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      chk("bank_final", bank[i], committed[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
